gpio_input_ctrl: RTL and testbench

GPIO_INPUT_CTRL -- requirements
Module: gpio_input_ctrl

---
 rtl/moggysoc_pkg.sv | 48 ++++
 rtl/gpio_debounce.sv | 63 ++++++
 rtl/gpio_input_ctrl.sv | 117 +++++++++++
 tb/tb_gpio_input_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/moggysoc_pkg.sv
// Shared constants for the GPIO input controller: input map, register
// offsets, debounce counter width and small decode helpers.
package moggysoc_pkg;

  // Six debounced inputs: two slide switches followed by four push buttons.
  localparam int NUM_INPUTS   = 6;
  localparam int NUM_SWITCHES = 2;

  localparam int IDX_SW0  = 0;
  localparam int IDX_SW1  = 1;
  localparam int IDX_BTN0 = 2;
  localparam int IDX_BTN1 = 3;
  localparam int IDX_BTN2 = 4;
  localparam int IDX_BTN3 = 5;

  // Byte offsets of the register map.
  localparam logic [3:0] OFF_STATUS = 4'h0;
  localparam logic [3:0] OFF_EVENT  = 4'h4;
  localparam logic [3:0] OFF_IRQ_EN = 4'h8;

  // Wide enough for any debounce length up to 2^20-1.
  localparam int DBNC_CNT_W = 20;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_EVENT  = 2'd1,
    REG_IRQ_EN = 2'd2,
    REG_NONE   = 2'd3
  } reg_sel_e;

  // Map a word-aligned byte address onto a register selector.
  function automatic reg_sel_e decode_addr(input logic [3:0] aligned_addr);
    reg_sel_e sel;
    case (aligned_addr)
      OFF_STATUS: sel = REG_STATUS;
      OFF_EVENT:  sel = REG_EVENT;
      OFF_IRQ_EN: sel = REG_IRQ_EN;
      default:    sel = REG_NONE;
    endcase
    return sel;
  endfunction

  // Switches report both edges; buttons report presses only.
  function automatic logic is_switch(input int idx);
    return (idx < NUM_SWITCHES);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One input lane: 2-flop synchronizer, stability counter, debounced level
// and single-cycle rise/fall pulses on the cycle the level is accepted.
module gpio_debounce
  import moggysoc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [DBNC_CNT_W-1:0] CNT_LAST = DBNC_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                  meta_q;
  logic                  sync_q;
  logic                  level_q;
  logic                  level_d;
  logic [DBNC_CNT_W-1:0] cnt_q;
  logic [DBNC_CNT_W-1:0] cnt_d;
  logic                  accept_d;

  // Count consecutive samples that disagree with the current level; any
  // agreeing sample restarts the count so short glitches are discarded.
  always_comb begin
    cnt_d    = cnt_q;
    level_d  = level_q;
    accept_d = 1'b0;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      accept_d = 1'b1;
      level_d  = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + DBNC_CNT_W'(1);
    end
  end

  // Synchronizer and debounce state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= din_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pulses coincide with the clock edge that updates level_q.
  assign level_o = level_q;
  assign rise_o  = accept_d & sync_q;
  assign fall_o  = accept_d & ~sync_q;

endmodule

// File: rtl/gpio_input_ctrl.sv
// GPIO input controller: six debounced inputs, sticky event register with
// write-1-to-clear, interrupt enables and a single-outstanding bus port.
module gpio_input_ctrl
  import moggysoc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [1:0]  switches,
  input  logic [3:0]  push_buttons,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        irq
);

  logic [NUM_INPUTS-1:0] raw_in;
  logic [NUM_INPUTS-1:0] level;
  logic [NUM_INPUTS-1:0] rise;
  logic [NUM_INPUTS-1:0] fall;
  logic [NUM_INPUTS-1:0] event_set;

  logic [NUM_INPUTS-1:0] event_q,  event_d;
  logic [NUM_INPUTS-1:0] irq_en_q, irq_en_d;
  logic                  irq_q;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;

  logic                  accept;
  reg_sel_e              sel;
  logic [31:0]           read_mux;
  logic [NUM_INPUTS-1:0] event_clr;

  // Address low bits and upper write-data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{req_addr[1:0], req_wdata[31:NUM_INPUTS]};

  assign raw_in = {push_buttons, switches};

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
      gpio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_dbnc (
        .clk_i  (sys_clk),
        .rst_i  (rst),
        .din_i  (raw_in[gi]),
        .level_o(level[gi]),
        .rise_o (rise[gi]),
        .fall_o (fall[gi])
      );
      assign event_set[gi] = rise[gi] | (is_switch(gi) ? fall[gi] : 1'b0);
    end
  endgenerate

  // A new request is refused only while an unconsumed response is held.
  assign req_ready = rst | ~rsp_valid_q | rsp_ready;
  assign accept    = req_valid & req_ready;
  assign sel       = decode_addr({req_addr[3:2], 2'b00});

  // Register read mux, bus write effects and response next-state.
  always_comb begin
    read_mux = '0;
    case (sel)
      REG_STATUS: read_mux = {{(32-NUM_INPUTS){1'b0}}, level};
      REG_EVENT:  read_mux = {{(32-NUM_INPUTS){1'b0}}, event_q};
      REG_IRQ_EN: read_mux = {{(32-NUM_INPUTS){1'b0}}, irq_en_q};
      default:    read_mux = '0;
    endcase

    event_clr = '0;
    irq_en_d  = irq_en_q;
    if (accept && req_write) begin
      if (sel == REG_EVENT)  event_clr = req_wdata[NUM_INPUTS-1:0];
      if (sel == REG_IRQ_EN) irq_en_d  = req_wdata[NUM_INPUTS-1:0];
    end
    // A fresh event wins over a clear landing on the same cycle.
    event_d = (event_q & ~event_clr) | event_set;

    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = req_write ? 32'd0 : read_mux;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Register state; irq follows EVENT/IRQ_EN with one cycle of delay.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      event_q     <= '0;
      irq_en_q    <= '0;
      irq_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      event_q     <= event_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= |(event_q & irq_en_q);
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_input_ctrl.sv
// Directed bench for gpio_input_ctrl with DEBOUNCE_CYCLES = 4. Bus reads push
// their expected data into a queue; a monitor pops on every consumed response.
module tb_gpio_input_ctrl;

  localparam int DBC = 4;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  switches = '0;
  logic [3:0]  push_buttons = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  gpio_input_ctrl #(
    .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .switches    (switches),
    .push_buttons(push_buttons),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .irq         (irq)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Issue one request; returns 1ns after the accepting clock edge.
  task automatic bus_op(input string name, input logic wr, input logic [3:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp, input bit track);
    int guard;
    guard     = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && guard < 50) begin
      tick(1);
      guard++;
    end
    if (!req_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: req_ready got 0, expected 1 within 50 cycles", name);
    end else begin
      if (track) exp_q.push_back('{name, exp});
      @(posedge sys_clk);
      #1;
    end
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic rd(input string name, input logic [3:0] addr, input logic [31:0] exp);
    bus_op(name, 1'b0, addr, 32'd0, exp, 1'b1);
  endtask

  task automatic wr(input string name, input logic [3:0] addr, input logic [31:0] data);
    bus_op(name, 1'b1, addr, data, 32'd0, 1'b1);
  endtask

  // Scoreboard monitor: a response is consumed on the next edge when both
  // rsp_valid and rsp_ready are seen high here.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL rsp_unexpected: got 0x%08h, expected no response", rsp_rdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check(e.name, rsp_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;

    // Reset state
    tick(3);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    tick(2);
    rd("status_init", 4'h0, 32'h00);
    rd("event_init",  4'h4, 32'h00);
    rd("irqen_init",  4'h8, 32'h00);

    // Button 0 held 10 cycles
    push_buttons[0] = 1'b1;
    tick(7);
    rd("btn0_status", 4'h0, 32'h04);
    rd("btn0_event",  4'h4, 32'h04);
    check("btn0_irq_masked", {31'd0, irq}, 32'd0);
    tick(1);
    push_buttons[0] = 1'b0;
    tick(8);
    rd("btn0_release_status", 4'h0, 32'h00);
    rd("btn0_release_event",  4'h4, 32'h04);
    wr("btn0_clear", 4'h4, 32'h04);
    rd("btn0_cleared", 4'h4, 32'h00);

    // 3-cycle glitch on button 1
    push_buttons[1] = 1'b1;
    tick(3);
    push_buttons[1] = 1'b0;
    tick(8);
    rd("glitch_status", 4'h0, 32'h00);
    rd("glitch_event",  4'h4, 32'h00);

    // Switch 1 toggle with interrupts enabled
    wr("irqen_write", 4'h8, 32'hFFFF_FF3F);
    rd("irqen_read",  4'h8, 32'h3F);
    switches[1] = 1'b1;
    tick(8);
    rd("sw1_status_hi", 4'h0, 32'h02);
    switches[1] = 1'b0;
    tick(8);
    rd("sw1_event", 4'h4, 32'h02);
    check("sw1_irq", {31'd0, irq}, 32'd1);
    wr("sw1_clear", 4'h4, 32'h02);
    tick(1);
    check("sw1_irq_cleared", {31'd0, irq}, 32'd0);
    rd("sw1_event_cleared", 4'h4, 32'h00);

    // EVENT read on the same cycle as a new set returns the old value
    push_buttons[2] = 1'b1;
    tick(5);
    rd("btn2_same_cycle_read", 4'h4, 32'h00);
    rd("btn2_event", 4'h4, 32'h10);

    // W1C colliding with a new button 3 event
    push_buttons[3] = 1'b1;
    tick(5);
    wr("btn3_collide_clear", 4'h4, 32'h20);
    rd("btn3_event_kept", 4'h4, 32'h30);
    wr("btn3_clear", 4'h4, 32'h20);
    rd("btn3_event_cleared", 4'h4, 32'h10);
    push_buttons[3:2] = 2'b00;
    tick(8);
    check("btn2_irq", {31'd0, irq}, 32'd1);

    // Response back-pressure
    tick(2);
    rsp_ready = 1'b0;
    rd("stall_read", 4'h8, 32'h3F);
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rsp_rdata", rsp_rdata, 32'h3F);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      tick(1);
    end
    rsp_ready = 1'b1;
    tick(1);
    rd("unmapped_read",  4'hC, 32'h00);
    wr("unmapped_write", 4'hC, 32'hFFFF_FFFF);
    rd("unmapped_reread", 4'hC, 32'h00);
    wr("status_write", 4'h0, 32'h0000_003F);
    rd("status_ro",    4'h0, 32'h00);

    // Reset mid-debounce and mid-response
    tick(1);
    switches[0] = 1'b1;
    tick(3);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    rsp_ready = 1'b0;
    bus_op("inflight_read", 1'b0, 4'h8, 32'd0, 32'h3F, 1'b0);
    check("inflight_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    switches[0] = 1'b0;
    push_buttons[0] = 1'b1;
    #1;
    check("rst_async_req_ready", {31'd0, req_ready}, 32'd1);
    tick(1);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_rsp_rdata", rsp_rdata, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    tick(1);
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick(10);
    rd("post_rst_status", 4'h0, 32'h04);
    rd("post_rst_event",  4'h4, 32'h04);
    rd("post_rst_irqen",  4'h8, 32'h00);
    check("post_rst_irq", {31'd0, irq}, 32'd0);

    // Drain the scoreboard
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      tick(1);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
